// File: rtl/inv_pipe_elastic.sv
// WIDTH-bit, DEPTH-stage elastic register pipeline with valid/ready handshake.
// Optional bitwise inversion is applied once, when stage 0 captures a beat.
module inv_pipe_elastic #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 3,
  parameter int INVERT = 1,
  parameter int CNT_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             inv_sel,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] occupancy
);

  logic [DEPTH-1:0] v_q, v_d;
  logic [DEPTH-1:0] r;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [WIDTH-1:0] cap_data;
  logic             accept;

  // A stage can take a new beat if it is empty or its content moves on this edge.
  always_comb begin
    r = '0;
    r[DEPTH-1] = !v_q[DEPTH-1] || out_ready;
    for (int unsigned k = DEPTH - 1; k > 0; k--) begin
      r[k-1] = !v_q[k-1] || r[k];
    end
  end

  assign in_ready = r[0] && !flush;
  assign accept   = in_valid && in_ready;
  assign cap_data = ((INVERT != 0) && inv_sel) ? ~in_data : in_data;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (r[0]) begin
      v_d[0] = accept;
      if (accept) d_d[0] = cap_data;
    end
    for (int unsigned k = 1; k < DEPTH; k++) begin
      if (r[k]) begin
        v_d[k] = v_q[k-1];
        if (v_q[k-1]) d_d[k] = d_q[k-1];
      end
    end
    // Flush drops every beat but leaves the data registers as they are.
    if (flush) v_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        d_q[k] <= '0;
      end
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign occupancy = CNT_W'($countones(v_q));

endmodule

// File: tb/tb_inv_pipe_elastic.sv
// Directed bench for inv_pipe_elastic: a default DEPTH=3 inverting instance
// and a DEPTH=1 non-inverting instance, both checked against data queues.
module tb_inv_pipe_elastic;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, inv_sel, flush, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [1:0] occupancy;

  logic       v2, rdy2, s2, f2, ov2, or2;
  logic [7:0] d2, od2;
  logic [0:0] occ2;

  int errors = 0;
  int checks = 0;
  int in_hs  = 0;
  int out_hs = 0;
  logic [7:0] q  [$];
  logic [7:0] q2 [$];

  always #5 clk = ~clk;

  inv_pipe_elastic #(.WIDTH(8), .DEPTH(3), .INVERT(1), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .inv_sel(inv_sel), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  inv_pipe_elastic #(.WIDTH(8), .DEPTH(1), .INVERT(0), .CNT_W(1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(rdy2),
    .in_data(d2), .inv_sel(s2), .flush(f2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2),
    .occupancy(occ2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Record handshakes just before the edge, then advance to 1 time unit after it.
  task automatic tick();
    logic [7:0] e;
    #1;
    if (in_valid && in_ready) begin
      q.push_back(inv_sel ? ~in_data : in_data);
      in_hs++;
    end
    if (out_valid && out_ready) begin
      out_hs++;
      check("sb_pending", 32'(q.size() > 0), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("sb_data", out_data, e);
      end
    end
    if (flush) q.delete();
    if (v2 && rdy2) q2.push_back(d2);
    if (ov2 && or2) begin
      check("sb2_pending", 32'(q2.size() > 0), 1);
      if (q2.size() > 0) begin
        e = q2.pop_front();
        check("sb2_data", od2, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic s);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    inv_sel  = s;
    #1;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("send_accept", in_ready, 1);
    tick();
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((q.size() > 0 || out_valid) && n < 30) begin
      tick();
      n++;
    end
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    int h0, n;
    logic [7:0] held;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; inv_sel = 1'b0; flush = 1'b0; out_ready = 1'b1;
    v2 = 1'b0; d2 = '0; s2 = 1'b0; f2 = 1'b0; or2 = 1'b1;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_out_valid2", ov2, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_in_ready2", rdy2, 1);

    // Stream of three beats, out_ready held high
    in_valid = 1'b1; in_data = 8'h00; inv_sel = 1'b1; tick();
    check("st1_valid", out_valid, 0); check("st1_occ", occupancy, 1);
    in_data = 8'h5A; inv_sel = 1'b0; tick();
    check("st2_valid", out_valid, 0); check("st2_occ", occupancy, 2);
    in_data = 8'hFF; inv_sel = 1'b1; tick();
    check("st3_valid", out_valid, 1); check("st3_occ", occupancy, 3);
    check("st3_data", out_data, 8'hFF);
    in_valid = 1'b0; tick();
    check("st4_valid", out_valid, 1); check("st4_data", out_data, 8'h5A);
    check("st4_occ", occupancy, 2);
    tick();
    check("st5_valid", out_valid, 1); check("st5_data", out_data, 8'h00);
    tick();
    check("st6_valid", out_valid, 0); check("st6_occ", occupancy, 0);

    // Back-pressure: five beats with the sink stalled
    out_ready = 1'b0; h0 = out_hs;
    send(8'h11, 1'b0); send(8'h22, 1'b1); send(8'h33, 1'b0);
    in_valid = 1'b1; in_data = 8'h44; inv_sel = 1'b0; #1;
    check("bp_in_ready", in_ready, 0);
    check("bp_occ", occupancy, 3);
    check("bp_valid", out_valid, 1);
    check("bp_data", out_data, 8'h11);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_data", out_data, 8'h11);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    send(8'h44, 1'b0); send(8'h55, 1'b0);
    drain();
    check("bp_delivered", out_hs - h0, 5);

    // Full pipeline with simultaneous push and pop
    out_ready = 1'b0;
    send(8'hA1, 1'b0); send(8'hA2, 1'b1); send(8'hA3, 1'b0);
    out_ready = 1'b1; in_valid = 1'b1;
    h0 = in_hs; n = out_hs;
    for (int i = 0; i < 10; i++) begin
      in_data = 8'($urandom); inv_sel = 1'($urandom);
      #1;
      check("full_in_ready", in_ready, 1);
      check("full_out_valid", out_valid, 1);
      tick();
      check("full_occ", occupancy, 3);
    end
    check("full_in_hs", in_hs - h0, 10);
    check("full_out_hs", out_hs - n, 10);
    drain();

    // Flush with two beats in flight and a beat offered
    out_ready = 1'b0;
    send(8'hB1, 1'b0); send(8'hB2, 1'b0);
    check("fl_occ_before", occupancy, 2);
    in_valid = 1'b1; in_data = 8'h77; flush = 1'b1; #1;
    check("fl_in_ready", in_ready, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_occ_after", occupancy, 0);
    check("fl_valid_after", out_valid, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("fl_no_reappear", out_valid, 0);
    end

    // Asynchronous reset while output is valid
    out_ready = 1'b0;
    send(8'hC1, 1'b0); send(8'hC2, 1'b0); send(8'hC3, 1'b0);
    in_valid = 1'b0;
    check("ar_valid_before", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_occ", occupancy, 0);
    q.delete(); q2.delete();
    rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h0F; inv_sel = 1'b1; tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    check("ar_latency", n, 3);
    check("ar_data", out_data, 8'hF0);
    drain();

    // DEPTH=1 without inversion
    or2 = 1'b1; v2 = 1'b1; d2 = 8'hA5; s2 = 1'b1; #1;
    check("d1_in_ready", rdy2, 1);
    tick();
    check("d1_valid", ov2, 1);
    check("d1_data", od2, 8'hA5);
    d2 = 8'h3C; s2 = 1'b0; #1;
    check("d1_b2b_ready1", rdy2, 1);
    tick();
    check("d1_b2b_data1", od2, 8'h3C);
    d2 = 8'hC3; s2 = 1'b1; #1;
    check("d1_b2b_ready2", rdy2, 1);
    tick();
    check("d1_b2b_data2", od2, 8'hC3);
    or2 = 1'b0; d2 = 8'h99; #1;
    check("d1_full_ready", rdy2, 0);
    check("d1_occ", occ2, 1);
    tick();
    check("d1_hold_data", od2, 8'hC3);
    or2 = 1'b1; v2 = 1'b0; tick(); tick();
    check("d1_empty", ov2, 0);
    check("d1_sb_empty", q2.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inv_pipe_elastic.md
Name: inv_pipe_elastic

Overview:
- Parametrised successor to the single-bit inverter cells: a WIDTH-bit, DEPTH-stage elastic pipeline with a valid/ready handshake.
- Optional bitwise inversion, selected per instance via INVERT or per beat via inv_sel.
- Used as a drop-in registered, back-pressurable driver between netlist-level blocks.
- Reports occupancy for the thermal/activity monitors.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 3, number of register stages (>=1).
- INVERT, 1, 1: inversion allowed; 0: inv_sel ignored, data passes unmodified.
- CNT_W, 2, width of occupancy output; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  pipeline can accept a beat this cycle.
- in_data  in  WIDTH  upstream data.
- inv_sel  in  1  invert this beat (sampled with in_data on acceptance).
- flush  in  1  synchronous clear of all stages.
- out_valid  out  1  last stage holds a beat.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  last-stage data.
- occupancy  out  CNT_W  number of valid stages.

Behaviour:
- One clock: clk. Reset is asynchronous and active-high on rst.
- Reset (async assert, release synchronous to clk):
  - all stage valid bits = 0; all stage data regs = 0.
  - out_valid=0, out_data=0, occupancy=0, in_ready=1 (after reset deasserts).
- Stage k (0..DEPTH-1) holds v[k] and d[k]. Stage DEPTH-1 drives out_valid/out_data.
- Ready chain (combinational):
  - r[DEPTH-1] = !v[DEPTH-1] || out_ready.
  - r[k] = !v[k] || r[k+1].
  - in_ready = r[0] && !flush.
- Transfers on each rising edge, no flush:
  - Stage k loads from stage k-1 (or from input for k=0) when r[k]=1.
  - v[k] <= v[k-1] (k=0: in_valid && in_ready).
  - Data regs load only when the source is valid, so d[k] holds stale values otherwise.
- Inversion is applied once, at stage-0 capture: d[0] <= (INVERT && inv_sel) ? ~in_data : in_data. Later stages copy unchanged.
- Latency: accepted beat appears on out_valid exactly DEPTH cycles later if out_ready stays 1.
- Throughput: 1 beat/cycle sustained, including when the pipeline is full and out_ready=1 (simultaneous pop and push).
- Back-pressure:
  - out_ready=0 with v[DEPTH-1]=1 holds out_data stable.
  - Bubbles collapse upstream until all DEPTH stages are full, then in_ready=0.
- AXI-style rule: out_valid, once high, stays high with out_data unchanged until out_ready=1. in_data is not required stable before acceptance.
- flush=1 at an edge:
  - all v <= 0; in_valid ignored that cycle (in_ready=0).
  - out_valid still reflects the current state that cycle, and a concurrent out_ready handshake counts as delivered.
  - Data regs are not cleared.
- occupancy = popcount(v). Updates the cycle after a transfer. Never exceeds DEPTH.
- DEPTH=1 degenerates to a single full register. r[0] = !v[0] || out_ready gives full throughput.
- Reset mid-stream: all in-flight beats are discarded with no partial output. out_valid falls asynchronously with rst.

Test Plan:
- Reset then stream, WIDTH=8, DEPTH=3, out_ready=1, INVERT=1:
  - send 0x00,0x5A,0xFF with inv_sel=1,0,1 on cycles 0-2.
  - expect out_data 0xFF,0x5A,0x00 with out_valid on cycles 3-5; occupancy peaks at 3.
- Back-pressure:
  - hold out_ready=0 while sending 5 beats.
  - expect in_ready=0 after 3 accepted, occupancy=3, out_data stable.
  - release out_ready; expect all 5 beats in order, no loss or duplication.
- Full-pipe simultaneous push/pop:
  - fill 3 stages, then set in_valid=1, out_ready=1 for 10 cycles.
  - expect 10 consecutive handshakes on each side; occupancy stays 3.
- Flush:
  - with occupancy=2, assert flush one cycle while in_valid=1.
  - expect in_ready=0 that cycle, occupancy=0 next cycle, flushed beats never reappear.
- Async reset mid-stream:
  - assert rst between clock edges while out_valid=1.
  - expect out_valid=0 and occupancy=0 immediately.
  - first beat after release appears with latency 3.
- INVERT=0, DEPTH=1:
  - send 0xA5 with inv_sel=1.
  - expect out_data=0xA5 after 1 cycle; back-to-back beats accepted every cycle with out_ready=1.
